// File: rtl/beamform_pkg.sv
// rtl/beamform_pkg.sv - shared widths, complex type and saturation helpers for the beamformer datapath
package beamform_pkg;

  localparam int DATA_W = 18;
  localparam int FRAC_W = 17;
  localparam int W_MAX  = 131071;
  localparam int W_MIN  = -131072;
  localparam int PROD_W = 2*DATA_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  typedef struct packed {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
  } cplx_t;

  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(W_MAX);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(W_MIN);

  function automatic logic is_sat(input logic signed [SUM_W-1:0] x);
    return (x > SUM_MAX) || (x < SUM_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] c;
    c = x;
    if (x > SUM_MAX) c = SUM_MAX;
    else if (x < SUM_MIN) c = SUM_MIN;
    return c[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cplx_mul_conj.sv
// rtl/cplx_mul_conj.sv - registered full-width u * conj(e) product
module cplx_mul_conj
  import beamform_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] u_i,
  input  logic signed [DATA_W-1:0] u_q,
  input  logic signed [DATA_W-1:0] e_i,
  input  logic signed [DATA_W-1:0] e_q,
  output logic signed [PROD_W-1:0] p_i,
  output logic signed [PROD_W-1:0] p_q,
  output logic                     p_valid
);

  logic signed [PROD_W-1:0] ux_i, ux_q, ex_i, ex_q;

  assign ux_i = PROD_W'(u_i);
  assign ux_q = PROD_W'(u_q);
  assign ex_i = PROD_W'(e_i);
  assign ex_q = PROD_W'(e_q);

  // Operands are widened first so -1 * -1 sums stay exact in PROD_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_i     <= '0;
      p_q     <= '0;
    end else begin
      p_valid <= in_valid & ~flush;
      if (in_valid && !flush) begin
        p_i <= ux_i * ex_i + ux_q * ex_q;
        p_q <= ux_q * ex_i - ux_i * ex_q;
      end
    end
  end

endmodule

// File: rtl/lms_weight_update.sv
// rtl/lms_weight_update.sv - complex LMS weight adaptation, optional leaky form via LMS_LEAKAGE_EN
module lms_weight_update
  import beamform_pkg::*;
#(
  parameter int MU_SHIFT   = 4,
  parameter int CNT_W      = 16,
  parameter int LEAK_SHIFT = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_w,
  input  logic signed [DATA_W-1:0] w_initI,
  input  logic signed [DATA_W-1:0] w_initQ,
  input  logic                     freeze,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] uinI,
  input  logic signed [DATA_W-1:0] uinQ,
  input  logic signed [DATA_W-1:0] eI,
  input  logic signed [DATA_W-1:0] eQ,
  output logic signed [DATA_W-1:0] wI,
  output logic signed [DATA_W-1:0] wQ,
  output logic                     w_valid,
  output logic                     sat_flag,
  output logic [CNT_W-1:0]         upd_count
);

  typedef enum logic [1:0] {INIT, ADAPT, HOLD} state_t;

  localparam int SH = FRAC_W + MU_SHIFT;
  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) <<< (SH - 1);

  state_t state_q, state_d;
  logic signed [PROD_W-1:0] p_i, p_q, d_i, d_q;
  logic signed [SUM_W-1:0]  sum_i, sum_q;
  logic p_valid, v2, commit;

  cplx_mul_conj u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .flush   (load_w),
    .u_i     (uinI),
    .u_q     (uinQ),
    .e_i     (eI),
    .e_q     (eQ),
    .p_i     (p_i),
    .p_q     (p_q),
    .p_valid (p_valid)
  );

  // S2: round half up, then scale by mu and drop the Q1.17 fraction in one shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      d_i <= '0;
      d_q <= '0;
    end else begin
      v2 <= p_valid & ~load_w;
      if (p_valid) begin
        d_i <= (p_i + RND) >>> SH;
        d_q <= (p_q + RND) >>> SH;
      end
    end
  end

`ifdef LMS_LEAKAGE_EN
  assign sum_i = SUM_W'(wI) - SUM_W'(wI >>> LEAK_SHIFT) + d_i;
  assign sum_q = SUM_W'(wQ) - SUM_W'(wQ >>> LEAK_SHIFT) + d_q;
`else
  assign sum_i = SUM_W'(wI) + SUM_W'(d_i);
  assign sum_q = SUM_W'(wQ) + SUM_W'(d_q);
`endif

  always_comb begin
    state_d = state_q;
    commit  = v2 && (state_q == ADAPT) && !freeze && !load_w;
    if (load_w) state_d = ADAPT;
    else begin
      case (state_q)
        INIT:    if (in_valid) state_d = ADAPT;
        ADAPT:   if (freeze)   state_d = HOLD;
        HOLD:    if (!freeze)  state_d = ADAPT;
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // S3: load wins over a commit landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wI        <= '0;
      wQ        <= '0;
      w_valid   <= 1'b0;
      sat_flag  <= 1'b0;
      upd_count <= '0;
    end else begin
      w_valid <= load_w | commit;
      if (load_w) begin
        wI <= w_initI;
        wQ <= w_initQ;
      end else if (commit) begin
        wI <= saturate(sum_i);
        wQ <= saturate(sum_q);
        if (is_sat(sum_i) || is_sat(sum_q)) sat_flag <= 1'b1;
        if (upd_count != {CNT_W{1'b1}}) upd_count <= upd_count + 1'b1;
      end
    end
  end

endmodule
